// File: rtl/serdes_pkg.sv
// Shared constants and types for the receive slicer / deserializer.
//   SYMBOL_W          : 10b line-code symbol width
//   K28_5_RDN         : K28.5 comma, running-disparity-negative form, bit 0 = first received
//   rx_align_state_e  : word-alignment FSM states
package serdes_pkg;

  localparam int unsigned SYMBOL_W = 10;

  localparam logic [SYMBOL_W-1:0] K28_5_RDN = 10'h17C;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } rx_align_state_e;

endpackage

// File: rtl/rx_slicer.sv
// Hysteresis slicer: turns the real-valued equalizer output into a hard bit decision.
// Ports:
//   clk       : receive clock
//   rst_n     : synchronous active-low reset
//   en        : UI sample strobe; the decision register only updates when high
//   sample_in : equalizer output (real)
//   decision  : combinational decision for the current sample
//   bit_out   : registered decision
module rx_slicer #(
  parameter real THRESHOLD = 0.5,
  parameter real HYST      = 0.05
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  real  sample_in,
  output logic decision,
  output logic bit_out
);

  logic bit_q;

  // Inside the band (edges included) the previous decision is kept.
  always_comb begin
    decision = bit_q;
    if (sample_in > THRESHOLD + HYST) begin
      decision = 1'b1;
    end else if (sample_in < THRESHOLD - HYST) begin
      decision = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_q <= 1'b0;
    end else if (en) begin
      bit_q <= decision;
    end
  end

  assign bit_out = bit_q;

endmodule

// File: rtl/rx_slicer_deser.sv
// Receive slicer + deserializer with K28.5 comma word alignment.
// Ports:
//   clk        : receive clock, one rising edge per candidate sample
//   rst_n      : synchronous active-low reset
//   sample_in  : equalizer output (real)
//   en         : UI sample strobe
//   bit_out    : registered slicer decision
//   data_out   : aligned symbol, bit 0 = first received bit
//   data_valid : one-cycle pulse per aligned symbol
//   aligned    : high while the aligner is LOCKED
//   comma_det  : one-cycle pulse when the current window is a comma of either disparity
module rx_slicer_deser
  import serdes_pkg::*;
#(
  parameter int unsigned      WIDTH      = SYMBOL_W,
  parameter real              THRESHOLD  = 0.5,
  parameter real              HYST       = 0.05,
  parameter logic [WIDTH-1:0] COMMA      = K28_5_RDN,
  parameter int unsigned      LOCK_COUNT = 3,
  parameter int unsigned      LOSS_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  real              sample_in,
  input  logic             en,
  output logic             bit_out,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             aligned,
  output logic             comma_det
);

  localparam int unsigned CntW  = $clog2(WIDTH);
  localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MissW = $clog2(LOSS_COUNT + 1);

  logic                decision;
  logic [WIDTH-1:0]    win;
  logic                match;
  logic                boundary;
  logic                valid_d;
  logic [WIDTH-1:0]    data_d;
  rx_align_state_e     state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [GoodW-1:0]    good_q, good_d, good_inc;
  logic [MissW-1:0]    miss_q, miss_d, miss_inc;
  // Only the upper WIDTH-1 window bits survive to the next shift, so bit 0 is never stored.
  logic [WIDTH-2:0]    hist_q;

  rx_slicer #(
    .THRESHOLD (THRESHOLD),
    .HYST      (HYST)
  ) u_slicer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sample_in (sample_in),
    .decision  (decision),
    .bit_out   (bit_out)
  );

  // Newest bit enters at the MSB so the oldest bit of a word ends up in bit 0.
  assign win      = {decision, hist_q};
  assign match    = (win == COMMA) || (win == ~COMMA);
  assign boundary = (cnt_q == CntW'(WIDTH - 1));
  assign good_inc = good_q + GoodW'(1);
  assign miss_inc = miss_q + MissW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    good_d  = good_q;
    miss_d  = miss_q;
    if (en) begin
      cnt_d = boundary ? '0 : cnt_q + CntW'(1);
      case (state_q)
        HUNT: begin
          if (match) begin
            // Realign: the matching bit becomes the last bit of a word.
            cnt_d   = '0;
            good_d  = GoodW'(1);
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (match && boundary) begin
            good_d = good_inc;
            if (good_inc == GoodW'(LOCK_COUNT)) begin
              state_d = LOCKED;
            end
          end else if (match) begin
            cnt_d  = '0;
            good_d = GoodW'(1);
          end
        end
        LOCKED: begin
          if (match && boundary) begin
            miss_d = '0;
          end else if (match) begin
            if (miss_inc == MissW'(LOSS_COUNT)) begin
              // Drop lock; this comma is deliberately not used to realign.
              state_d = HUNT;
              good_d  = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  // Loss of lock only happens off-boundary, so at a boundary state_d == LOCKED covers
  // both "already locked" and "locking on this cycle".
  always_comb begin
    valid_d = en && boundary && (state_d == LOCKED);
    data_d  = valid_d ? win : data_out;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      cnt_q      <= '0;
      good_q     <= '0;
      miss_q     <= '0;
      hist_q     <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      aligned    <= 1'b0;
      comma_det  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      good_q     <= good_d;
      miss_q     <= miss_d;
      if (en) begin
        hist_q <= win[WIDTH-1:1];
      end
      data_out   <= data_d;
      data_valid <= valid_d;
      aligned    <= (state_d == LOCKED);
      comma_det  <= en && match;
    end
  end

endmodule

// File: doc/rx_slicer_deser.md
Name: rx_slicer_deser

Overview:
- Receive-side stage directly downstream of the CTLE equalizer model.
- Slices the real-valued equalizer output once per UI against a hysteresis threshold, then shifts the recovered bits into 10-bit words.
- Aligns word boundaries on the K28.5 comma.
- Delivers aligned 10-bit symbols with a valid strobe to the 8b10b decoder.

Parameters:
- WIDTH, 10, symbol width in bits.
- THRESHOLD, 0.5 (real), slicer decision midpoint.
- HYST, 0.05 (real), half-width of the hysteresis band.
- COMMA, 10'h17C, K28.5 RD- pattern. Bit 0 is the first received bit (a). RD+ is ~COMMA = 10'h283.
- LOCK_COUNT, 3, on-boundary commas required to declare alignment.
- LOSS_COUNT, 4, off-boundary commas that drop alignment.

Ports:
- clk  in  1  receive clock, one rising edge per candidate sample.
- rst_n  in  1  synchronous, active-low reset.
- sample_in  in  real  equalizer output.
- en  in  1  sample strobe; high marks a UI sample point.
- bit_out  out  1  registered slicer decision.
- data_out  out  WIDTH  aligned symbol, bit 0 = first received bit.
- data_valid  out  1  one-cycle pulse per aligned symbol.
- aligned  out  1  high while state == LOCKED.
- comma_det  out  1  one-cycle pulse when the window matches COMMA or ~COMMA.

Behaviour:
- One clock; reset is synchronous and active-low, sampled on the rising edge of clk.
- Reset values (rst_n==0 at the edge):
  - bit_out=0, data_out=0, data_valid=0, aligned=0, comma_det=0.
  - Shift register = 0, bit_cnt = 0, good_cnt = 0, miss_cnt = 0, state = HUNT.
  - Reset mid-word or mid-lock discards everything in flight.
- en==0: all state holds; data_valid=0 and comma_det=0 on that cycle.
- Slicer (en==1), decision d:
  - d=1 if sample_in > THRESHOLD+HYST.
  - d=0 if sample_in < THRESHOLD-HYST.
  - Otherwise d = previous bit_out. Exactly at a band edge counts as inside the band, so the bit holds.
- bit_out <= d.
- Window: win = {d, sreg[WIDTH-1:1]}; sreg <= win. After WIDTH shifts, the first-received bit sits in bit 0.
- match = (win==COMMA) || (win==~COMMA); comma_det <= match.
- boundary = (bit_cnt == WIDTH-1).
- bit_cnt increments per en and wraps WIDTH-1 -> 0. On realignment it is forced so that the matching bit is WIDTH-1, i.e. bit_cnt <= 0 next.
- FSM, evaluated only when en==1:
  - HUNT:
    - match -> realign, good_cnt <= 1, go VERIFY.
    - Else stay.
  - VERIFY:
    - match && boundary -> good_cnt+1. If that reaches LOCK_COUNT, go LOCKED.
    - match && !boundary -> realign, good_cnt <= 1, stay VERIFY.
    - Non-comma words at a boundary are ignored.
  - LOCKED:
    - match && boundary -> miss_cnt <= 0.
    - match && !boundary -> miss_cnt+1. If that reaches LOSS_COUNT, go HUNT with good_cnt = 0, miss_cnt = 0, aligned = 0. The same-cycle match is not reused for realignment.
- Output:
  - At a boundary, when state is LOCKED or the FSM transitions to LOCKED on this cycle: data_out <= win, data_valid <= 1.
  - Otherwise data_valid <= 0 and data_out holds.
- Latency: outputs reflect the sample taken at edge k immediately after edge k, i.e. one clock register stage.
- aligned is registered and equals (next state == LOCKED).

Decomposition:
- serdes_pkg holds:
  - K28_5_RDN = 10'h17C.
  - SYMBOL_W = 10.
  - typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} rx_align_state_e.
- One sub-module, rx_slicer: hysteresis comparator plus the bit_out register, with en and rst_n.
- FSM, shift register and counters stay in rx_slicer_deser.

Test Plan:
1. Reset: rst_n=0 for 3 clks with en=1, sample_in=1.0 -> bit_out=0, data_valid=0, aligned=0, comma_det=0. First en after release with sample_in=1.0 -> bit_out=1.
2. Hysteresis: en=1, sample_in = 0.9, 0.52, 0.30, 0.48, 0.56, 0.6 -> bit_out = 1,1,0,0,1,1. The value 0.55 exactly holds the previous bit.
3. Lock: 3 bits of noise, then K28.5 (bits 0,0,1,1,1,1,1,0,1,0), word 10'h2AA, K28.5, 10'h155, K28.5, 10'h0F0, K28.5 RD+ (10'h283) ->
   - aligned rises on the edge of the last bit of the 3rd comma, with data_valid=1 and data_out=10'h17C there.
   - data_valid pulses every 10 en cycles thereafter: 10'h0F0, then 10'h283.
4. Loss/relock: while LOCKED, insert one extra bit, then continue the comma-rich stream -> every comma is off-boundary.
   - aligned falls on the 4th off-boundary comma.
   - aligned re-rises after 3 further boundary-consistent commas.
   - data_valid never pulses while aligned=0.
5. en gaps: repeat test 3 with en low for 1-5 random cycles between samples -> identical data_out sequence. data_valid and comma_det are 0 on every en=0 cycle.
6. Reset mid-operation: LOCKED, rst_n=0 for 1 clk at bit 4 of a word -> next cycle aligned=0, data_out=0. Relock requires 3 fresh commas.
